// File: rtl/smul_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : smul_ctrl_pkg
// Brief    : Shared types and encodings for the smul sequencer: FSM states,
//            operating-mode struct, precision and FP-unit encodings.
//            Precision codes are kept here with the same values as
//            precision_def.vh so this slice compiles standalone.
// Revision : 1.0  initial release
// ============================================================================
package smul_ctrl_pkg;

    // Precision select codes presented to smul
    localparam logic [3:0] PREC_INT8  = 4'b0001;
    localparam logic [3:0] PREC_INT16 = 4'b0010;
    localparam logic [3:0] PREC_INT32 = 4'b0100;
    localparam logic [3:0] PREC_INT64 = 4'b1000;

    // FP unit enable codes
    localparam logic [1:0] FP_INT   = 2'd0;
    localparam logic [1:0] FP_FP16  = 2'd1;
    localparam logic [1:0] FP_BFP16 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] prec;
        logic [1:0] fp;
        logic       chain;
    } mode_t;

    localparam mode_t MODE_RESET = '{prec: PREC_INT64, fp: FP_INT, chain: 1'b0};

endpackage
`default_nettype wire

// File: rtl/smul_ctrl_ofifo.sv
`default_nettype none
// ============================================================================
// Module   : smul_ctrl_ofifo
// Brief    : Fall-through result FIFO with occupancy count. Head entry is
//            visible on rdata_o whenever valid_o is high; output reads zero
//            while empty. DEPTH must be a power of two (pointers wrap freely).
// Revision : 1.0  initial release
// ============================================================================
module smul_ctrl_ofifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == (AW+1)'(DEPTH));
    assign w_do_pop  = pop_i & ~w_empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle
    assign w_do_push = push_i & (~w_full | w_do_pop);

    // Storage array: data only, no reset needed since output is masked when empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    assign valid_o = ~w_empty;
    assign rdata_o = w_empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/smul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : smul_ctrl
// Brief    : Sequencer in front of one smul multiply/MAC unit. Accepts
//            operand beats with per-beat mode, drains and clears smul on every
//            mode change and after each completed chain, and returns results
//            through a credit-protected fall-through FIFO.
//            Optional macro SMUL_CTRL_PERF_EN adds saturating perf counters.
// Revision : 1.0  initial release
// ============================================================================
module smul_ctrl
    import smul_ctrl_pkg::*;
#(
    parameter int LATENCY     = 2,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_data,
    input  logic [63:0] req_weight,
    input  logic [3:0]  req_prec,
    input  logic [1:0]  req_fp,
    input  logic        req_chain,
    input  logic        req_last,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic        smul_ce,
    output logic        smul_sclr,
    output logic        smul_active_chain,
    output logic [3:0]  smul_select_precision,
    output logic [1:0]  smul_enable_fp_unit,
    output logic [63:0] smul_input_data,
    output logic [63:0] smul_weight,
    input  logic [63:0] smul_res,
    output logic        busy
`ifdef SMUL_CTRL_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_clears,
    output logic [31:0] perf_stall
`endif
);

    localparam int CW = $clog2(OFIFO_DEPTH) + 1;

    state_e             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic               clr_needed_q, clr_needed_d;
    logic [LATENCY-1:0] sr_valid_q;
    logic [LATENCY-1:0] sr_push_q;

    mode_t              w_req_mode;
    mode_t              w_drive_mode;
    logic               w_mismatch;
    logic               w_issue;
    logic               w_push_flag;
    logic               w_sr_empty;
    logic               w_credit_ok;
    logic [CW-1:0]      w_inflight;
    logic [CW-1:0]      w_fifo_count;
    logic [CW:0]        w_credit_sum;
    logic               w_fifo_push;
    logic               w_fifo_pop;

    assign w_req_mode = '{prec: req_prec, fp: req_fp, chain: req_chain};
    // A pending clear (after reset or a finished chain) counts as a mismatch
    assign w_mismatch  = clr_needed_q | (w_req_mode != mode_q);
    assign w_sr_empty  = (sr_valid_q == '0);
    assign w_push_flag = ~req_chain | req_last;

    // Count results still travelling through smul that will land in the FIFO
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + CW'(sr_valid_q[i] & sr_push_q[i]);
        end
    end

    assign w_credit_sum = {1'b0, w_fifo_count} + {1'b0, w_inflight};
    assign w_credit_ok  = (w_credit_sum < (CW+1)'(OFIFO_DEPTH));
    assign req_ready    = (state_q == ST_RUN) & ~w_mismatch & w_credit_ok;
    assign w_issue      = req_valid & req_ready;

    // State, mode and pending-clear registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_RESET;
            clr_needed_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            clr_needed_q <= clr_needed_d;
        end
    end

    // Next-state logic for the issue/drain/clear sequencer
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        clr_needed_d = clr_needed_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = w_mismatch ? ST_CLEAR : ST_RUN;
                end
            end
            ST_RUN: begin
                if (req_valid && w_mismatch) begin
                    state_d = ST_DRAIN;
                end else if (w_issue && req_chain && req_last) begin
                    // Accumulator must be zeroed before anything else runs
                    state_d      = ST_DRAIN;
                    clr_needed_d = 1'b1;
                end else if (!req_valid && w_sr_empty) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_sr_empty) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (req_valid) begin
                    mode_d = w_req_mode;
                end
                clr_needed_d = 1'b0;
                state_d      = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue tracking: one bit per smul pipeline stage plus its push flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_valid_q <= '0;
            sr_push_q  <= '0;
        end else begin
            sr_valid_q[0] <= w_issue;
            sr_push_q[0]  <= w_issue & w_push_flag;
            for (int i = 1; i < LATENCY; i++) begin
                sr_valid_q[i] <= sr_valid_q[i-1];
                sr_push_q[i]  <= sr_push_q[i-1];
            end
        end
    end

    // smul control: the clear cycle already presents the incoming beat's mode;
    // operands are zeroed when not issuing so idle cycles add nothing to a MAC
    always_comb begin
        w_drive_mode          = (state_q == ST_CLEAR && req_valid) ? w_req_mode : mode_q;
        smul_ce               = (state_q != ST_IDLE) | ~w_sr_empty;
        smul_sclr             = (state_q == ST_CLEAR);
        smul_active_chain     = w_drive_mode.chain;
        smul_select_precision = w_drive_mode.prec;
        smul_enable_fp_unit   = w_drive_mode.fp;
        smul_input_data       = w_issue ? req_data : '0;
        smul_weight           = w_issue ? req_weight : '0;
    end

    assign w_fifo_push = sr_valid_q[LATENCY-1] & sr_push_q[LATENCY-1];
    assign w_fifo_pop  = res_valid & res_ready;

    smul_ctrl_ofifo #(
        .DEPTH (OFIFO_DEPTH),
        .WIDTH (64)
    ) u_ofifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_fifo_push),
        .wdata_i (smul_res),
        .pop_i   (w_fifo_pop),
        .rdata_o (res_data),
        .valid_o (res_valid),
        .count_o (w_fifo_count)
    );

    assign busy = (state_q != ST_IDLE) | ~w_sr_empty | res_valid;

`ifdef SMUL_CTRL_PERF_EN
    logic [31:0] perf_issued_q, perf_clears_q, perf_stall_q;

    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issued_q <= '0;
            perf_clears_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (w_issue && perf_issued_q != '1) begin
                perf_issued_q <= perf_issued_q + 32'd1;
            end
            if (state_q == ST_CLEAR && perf_clears_q != '1) begin
                perf_clears_q <= perf_clears_q + 32'd1;
            end
            if (req_valid && !req_ready && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_clears = perf_clears_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_smul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_smul_ctrl
// Brief    : Self-checking bench for smul_ctrl with a behavioural smul model
//            (2-cycle multiply / MAC) and a result scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_smul_ctrl;
    import smul_ctrl_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [63:0] req_data, req_weight;
    logic [3:0]  req_prec;
    logic [1:0]  req_fp;
    logic        req_chain, req_last;
    logic        res_valid, res_ready;
    logic [63:0] res_data;
    logic        smul_ce, smul_sclr, smul_active_chain;
    logic [3:0]  smul_select_precision;
    logic [1:0]  smul_enable_fp_unit;
    logic [63:0] smul_input_data, smul_weight;
    logic [63:0] smul_res;
    logic        busy;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          sclr_cnt = 0;
    logic [3:0]  clr_prec = '0;
    logic [1:0]  clr_fp   = '0;
    logic [63:0] exp_q[$];
    logic [63:0] chain_acc = '0;

    // Behavioural smul: product stage then result/accumulate stage
    logic [63:0] m_s0  = '0;
    logic [63:0] m_res = '0;
    assign smul_res = m_res;

    always @(posedge clk) begin
        if (smul_ce) begin
            if (smul_sclr) begin
                m_s0  <= '0;
                m_res <= '0;
            end else begin
                m_s0  <= smul_input_data * smul_weight;
                m_res <= smul_active_chain ? (m_res + m_s0) : m_s0;
            end
        end
    end

    always #5 clk = ~clk;

    smul_ctrl #(
        .LATENCY     (LAT),
        .OFIFO_DEPTH (DEPTH)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_data              (req_data),
        .req_weight            (req_weight),
        .req_prec              (req_prec),
        .req_fp                (req_fp),
        .req_chain             (req_chain),
        .req_last              (req_last),
        .res_valid             (res_valid),
        .res_ready             (res_ready),
        .res_data              (res_data),
        .smul_ce               (smul_ce),
        .smul_sclr             (smul_sclr),
        .smul_active_chain     (smul_active_chain),
        .smul_select_precision (smul_select_precision),
        .smul_enable_fp_unit   (smul_enable_fp_unit),
        .smul_input_data       (smul_input_data),
        .smul_weight           (smul_weight),
        .smul_res              (smul_res),
        .busy                  (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result monitor: pops the scoreboard on every accepted result
    always @(negedge clk) begin
        if (smul_sclr) begin
            sclr_cnt++;
            clr_prec = smul_select_precision;
            clr_fp   = smul_enable_fp_unit;
        end
        if (res_valid && res_ready) begin
            check("res_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("res_data", res_data, exp_q.pop_front());
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [63:0] w,
                             input logic [3:0] p, input logic [1:0] f,
                             input logic ch, input logic lst, output int waits);
        logic [63:0] prod;
        waits      = 0;
        req_data   = d;
        req_weight = w;
        req_prec   = p;
        req_fp     = f;
        req_chain  = ch;
        req_last   = lst;
        req_valid  = 1'b1;
        @(negedge clk);
        while (!req_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        check("req_accept", 64'(req_ready), 64'd1);
        if (req_ready) begin
            check("issue_data", smul_input_data, d);
            check("issue_prec", 64'(smul_select_precision), 64'(p));
            check("issue_fp", 64'(smul_enable_fp_unit), 64'(f));
            prod = d * w;
            if (ch) begin
                chain_acc = chain_acc + prod;
                if (lst) begin
                    exp_q.push_back(chain_acc);
                    chain_acc = '0;
                end
            end else begin
                exp_q.push_back(prod);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("idle_reached", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        int s0;
        logic [63:0] a, b;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_data   = '0;
        req_weight = '0;
        req_prec   = PREC_INT64;
        req_fp     = FP_INT;
        req_chain  = 1'b0;
        req_last   = 1'b0;
        res_ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", res_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ce", 64'(smul_ce), 64'd0);
        check("rst_sclr", 64'(smul_sclr), 64'd0);
        check("rst_prec", 64'(smul_select_precision), 64'(PREC_INT64));
        check("rst_in_data", smul_input_data, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single INT64 beat: latency and one clear beforehand
        s0 = sclr_cnt;
        send_beat(64'hcafecafecafecafe, 64'hFFFFFFFFFFFFFFFF, PREC_INT64, FP_INT, 1'b0, 1'b0, waits);
        check("t1_sclr_once", 64'(sclr_cnt - s0), 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("t1_not_yet", 64'(res_valid), 64'd0);
        @(negedge clk);
        check("t1_valid_at_lat", 64'(res_valid), 64'd1);
        check("t1_value", res_data, 64'h3501350135013502);
        wait_idle();

        // 8 back-to-back INT32 beats
        s0 = sclr_cnt;
        for (int i = 0; i < 8; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            send_beat(a, b, PREC_INT32, FP_INT, 1'b0, 1'b0, waits);
            if (i > 0) check("t2_no_stall", 64'(waits), 64'd0);
        end
        wait_idle();
        check("t2_single_clear", 64'(sclr_cnt - s0), 64'd1);

        // Backpressure: DEPTH beats buffered, next one stalls
        res_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            send_beat(a, b, PREC_INT32, FP_INT, 1'b0, 1'b0, waits);
            if (i > 0) check("t3_fill_no_stall", 64'(waits), 64'd0);
        end
        a = 64'h0123456789abcdef;
        b = 64'h0000000000000003;
        req_data   = a;
        req_weight = b;
        req_valid  = 1'b1;
        repeat (5) @(negedge clk);
        check("t3_ready_dropped", 64'(req_ready), 64'd0);
        check("t3_res_held", 64'(res_valid), 64'd1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        send_beat(a, b, PREC_INT32, FP_INT, 1'b0, 1'b0, waits);
        send_beat(64'd77, 64'd1000, PREC_INT32, FP_INT, 1'b0, 1'b0, waits);
        wait_idle();

        // INT8 stream then switch to fp16 mid-stream
        for (int i = 0; i < 3; i++) begin
            send_beat(64'(i + 5), 64'(i + 11), PREC_INT8, FP_INT, 1'b0, 1'b0, waits);
        end
        s0 = sclr_cnt;
        send_beat(64'h3c00, 64'h4000, PREC_INT16, FP_FP16, 1'b0, 1'b0, waits);
        check("t4_switch_wait", 64'(waits), 64'(LAT + 2));
        check("t4_one_clear", 64'(sclr_cnt - s0), 64'd1);
        check("t4_clear_fp", 64'(clr_fp), 64'(FP_FP16));
        check("t4_clear_prec", 64'(clr_prec), 64'(PREC_INT16));
        send_beat(64'h1111, 64'h2222, PREC_INT16, FP_FP16, 1'b0, 1'b0, waits);
        check("t4_resume", 64'(waits), 64'd0);
        wait_idle();

        // Two back-to-back chains; the second must start on a cleared accumulator
        s0 = sclr_cnt;
        for (int i = 0; i < 4; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            send_beat(a, b, PREC_INT16, FP_INT, 1'b1, (i == 3), waits);
        end
        check("t5_entry_clear", 64'(sclr_cnt - s0), 64'd1);
        s0 = sclr_cnt;
        send_beat(64'd9, 64'd9, PREC_INT16, FP_INT, 1'b1, 1'b0, waits);
        check("t5_chain_clear_wait", 64'(waits), 64'(LAT + 2));
        check("t5_chain_clear", 64'(sclr_cnt - s0), 64'd1);
        send_beat(64'd10, 64'd20, PREC_INT16, FP_INT, 1'b1, 1'b1, waits);
        wait_idle();

        // Reset with beats in flight and results queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_beat(64'(i + 100), 64'(i + 3), PREC_INT64, FP_INT, 1'b0, 1'b0, waits);
        end
        reset = 1'b1;
        @(negedge clk);
        check("t6_res_valid", 64'(res_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_req_ready", 64'(req_ready), 64'd0);
        exp_q.delete();
        chain_acc = '0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        res_ready = 1'b1;
        s0 = sclr_cnt;
        send_beat(64'hcafecafecafecafe, 64'hFFFFFFFFFFFFFFFF, PREC_INT64, FP_INT, 1'b0, 1'b0, waits);
        check("t6_post_reset_clear", 64'(sclr_cnt - s0), 64'd1);
        wait_idle();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
